// File: rtl/ping_pong_display_pkg.sv
// Shared seven-segment code constants and anode patterns for the display blocks.
// All codes are active-low, ordered {g,f,e,d,c,b,a}.
package ping_pong_display_pkg;

    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegUp    = 7'b0011100;
    localparam logic [6:0] SegDown  = 7'b0100011;

    localparam logic [3:0] AnDig0 = 4'b1110;
    localparam logic [3:0] AnDig1 = 4'b1101;
    localparam logic [3:0] AnDig2 = 4'b1011;
    localparam logic [3:0] AnDig3 = 4'b0111;

    function automatic logic [3:0] an_for_index(input logic [1:0] idx);
        logic [3:0] an;
        unique case (idx)
            2'd0:    an = AnDig0;
            2'd1:    an = AnDig1;
            2'd2:    an = AnDig2;
            default: an = AnDig3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/ping_pong_display_seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes above 9 render blank.
module seg7_decode
    import ping_pong_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SegBlank;
        case (digit)
            4'd0:    seg = Seg0;
            4'd1:    seg = Seg1;
            4'd2:    seg = Seg2;
            4'd3:    seg = Seg3;
            4'd4:    seg = Seg4;
            4'd5:    seg = Seg5;
            4'd6:    seg = Seg6;
            4'd7:    seg = Seg7;
            4'd8:    seg = Seg8;
            4'd9:    seg = Seg9;
            default: seg = SegBlank;
        endcase
    end

endmodule

// File: rtl/ping_pong_display.sv
// Four-digit multiplexed display of the ping-pong counter: ones, tens and a
// direction glyph on the two left digits, refreshed from a per-frame snapshot.
module ping_pong_display
    import ping_pong_display_pkg::*;
#(
    parameter int unsigned REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] value,
    input  logic       direction,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [REFRESH_BITS-1:0] PrescaleOne = REFRESH_BITS'(1);

    logic [REFRESH_BITS-1:0] prescale_q;
    logic [1:0]              idx_q, idx_d;
    logic [3:0]              snap_val_q, snap_val_d;
    logic                    snap_dir_q, snap_dir_d;
    logic                    tick, wrap;
    logic                    has_tens;
    logic [3:0]              ones_digit, tens_digit;
    logic [6:0]              ones_seg, tens_seg;
    logic [3:0]              an_d;
    logic [6:0]              seg_d;

    assign tick = &prescale_q;
    assign wrap = tick && (idx_q == 2'd3);

    // Snapshot only at the frame boundary so a frame never mixes two samples.
    always_comb begin
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_dir_d = snap_dir_q;
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
        if (wrap) begin
            snap_val_d = value;
            snap_dir_d = direction;
        end
    end

    assign has_tens   = (snap_val_d >= 4'd10);
    assign ones_digit = has_tens ? (snap_val_d - 4'd10) : snap_val_d;
    assign tens_digit = has_tens ? 4'd1 : 4'hF;

    seg7_decode u_ones (
        .digit (ones_digit),
        .seg   (ones_seg)
    );

    seg7_decode u_tens (
        .digit (tens_digit),
        .seg   (tens_seg)
    );

    always_comb begin
        an_d  = an_for_index(idx_d);
        seg_d = snap_dir_d ? SegDown : SegUp;
        unique case (idx_d)
            2'd0:    seg_d = ones_seg;
            2'd1:    seg_d = tens_seg;
            default: seg_d = snap_dir_d ? SegDown : SegUp;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= '0;
            idx_q      <= 2'd0;
            snap_val_q <= 4'd0;
            snap_dir_q <= 1'b0;
            an         <= AnDig0;
            seg        <= Seg0;
        end else begin
            prescale_q <= prescale_q + PrescaleOne;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dir_q <= snap_dir_d;
            if (tick) begin
                an  <= an_d;
                seg <= seg_d;
            end
        end
    end

endmodule

// File: doc/ping_pong_display.md
PING_PONG_DISPLAY -- requirements
Module: ping_pong_display

Interface
REQ-001 The block SHALL have one parameter: REFRESH_BITS, default 17, log2 of the clock cycles each digit is lit.
REQ-002 Port clk  input  1  the only clock; every register SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port value  input  4  counter value to display, 0..15 unsigned, driven by the ping-pong counter's out.
REQ-005 Port direction  input  1  counter direction, 0 = counting up, 1 = counting down.
REQ-006 Port an  output  4  digit anode enables, active-low, one-hot-low; an[0] is the rightmost digit.
REQ-007 Port seg  output  7  segment drives, active-low, seg[6:0] = {g,f,e,d,c,b,a}.

Function
REQ-008 The prescaler SHALL be a REFRESH_BITS-wide free-running counter wrapping from all-ones to 0; a tick SHALL occur in a cycle where the prescaler is all-ones.
REQ-009 A 2-bit digit index SHALL advance on each tick edge, 0->1->2->3->0.
REQ-010 an and seg SHALL be registers loaded on the tick edge with the pattern for the new index; between ticks they SHALL hold.
REQ-011 Index 0 SHALL light an=4'b1110 and show the ones digit, value mod 10.
REQ-012 Index 1 SHALL light an=4'b1101 and show the tens digit, 1 when value>=10; when value<10 seg SHALL be 7'b1111111 (leading-zero blank).
REQ-013 Index 2 and index 3 (an=4'b1011, an=4'b0111) SHALL both show the direction glyph: 7'b0011100 (a,b,f,g, upper half) for direction 0 and 7'b0100011 (c,d,e,g, lower half) for direction 1.
REQ-014 Digit codes SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 value and direction SHALL be sampled into a snapshot register only on the tick edge where the index wraps 3->0; that edge SHALL use the newly sampled values for the index-0 pattern.
REQ-016 Input changes between snapshot edges SHALL NOT affect an or seg; no frame SHALL mix two samples (no tearing).
REQ-017 Tens/ones SHALL be derived by compare-and-subtract against 10 on the 4-bit snapshot; no divider.
REQ-018 Exactly one an bit SHALL be low in every cycle, including the cycle after reset release.

Reset
REQ-019 While rst_n is low, prescaler=0, index=0, snapshot value=0, snapshot direction=0, an=4'b1110, seg=7'b1000000, all regardless of clk.
REQ-020 Reset asserted mid-frame SHALL force REQ-019 values immediately; after release the first tick SHALL occur at the 2^REFRESH_BITS-th rising edge.
REQ-021 The first displayed frame after reset SHALL show the reset snapshot until the first 3->0 wrap.

Structure
REQ-022 A shared package SHALL hold the seven-segment code constants (digits 0-9, blank, up glyph, down glyph) and the anode patterns, for reuse by other display blocks.
REQ-023 A combinational sub-module seg7_decode (4-bit digit in, 7-bit active-low code out, blank for inputs >9) SHALL be instantiated for the ones and tens digits.

Verification (REFRESH_BITS=2, tick every 4 cycles)
REQ-024 Reset, hold value=0 dir=0 -> an cycles 1110,1101,1011,0111 with a 4-cycle period; seg 1000000, 1111111, 0011100, 0011100.
REQ-025 value=13 dir=1 applied before a 3->0 wrap -> ones 0110000, tens 1111001, glyphs 0100011 for the whole next frame.
REQ-026 value changes 5->6 while index=1 -> current frame keeps 5 (0010010); 6 (0000010) appears only after the next 3->0 wrap.
REQ-027 Sweep value 0..15 across frames -> ones/tens match REQ-014; tens blank for 0..9, 1111001 for 10..15.
REQ-028 Assert rst_n low mid-frame for 3 cycles without a clk edge -> an=1110, seg=1000000 immediately; first tick 4 edges after release.
REQ-029 Every cycle, checker asserts exactly one zero in an.
